// File: rtl/pipa_pkg.sv
// Shared types, default parameters and the saturating adder for the PIPA pulse generator.
package pipa_pkg;

    // Default build parameters for the generator and its axis channels
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_THRESH    = 1024;
    localparam int DEF_PULSE_CYC = 4;

    // Axis identifiers, used as bit positions in the per-axis flag and pulse vectors
    typedef enum logic [1:0] {
        AX_X = 2'd0,
        AX_Y = 2'd1,
        AX_Z = 2'd2
    } axis_e;

    // Per-axis channel state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND_P = 2'd1,
        ST_PEND_M = 2'd2,
        ST_PULSE  = 2'd3
    } axis_state_e;

    // Saturated sum plus a flag telling whether clipping happened
    typedef struct packed {
        logic               clip;
        logic signed [31:0] val;
    } sat_res_t;

    // Adds a and b and clips symmetrically to +/-(2^(w-1)-1); valid for w <= 31
    function automatic sat_res_t sat_add(input int a, input int b, input int w);
        sat_res_t r;
        int       lim;
        int       sum;
        lim    = (1 << (w - 1)) - 1;
        sum    = a + b;
        r.clip = 1'b0;
        r.val  = sum;
        if (sum > lim) begin
            r.val  = lim;
            r.clip = 1'b1;
        end else if (sum < -lim) begin
            r.val  = -lim;
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipa_axis.sv
// One PIPA loop channel: phase accumulator, pend/pulse FSM, pulse-width counter and sticky flags.
module pipa_axis
    import pipa_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int THRESH    = DEF_THRESH,
    parameter int PULSE_CYC = DEF_PULSE_CYC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    asw_e_i,
    input  logic                    dat_e_i,
    input  logic                    enable_i,
    input  logic signed [ACC_W-1:0] rate_i,
    input  logic                    clr_flags_i,
    output logic                    pulse_p_o,
    output logic                    pulse_m_o,
    output logic                    sat_o,
    output logic                    late_o
);

    localparam int             CNT_W    = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYC - 1);

    axis_state_e             state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dir_q, dir_d;     // 1 = minus pulse pending/active
    logic                    sat_q, sat_d;
    logic                    late_q, late_d;
    logic                    pulse_p_q, pulse_p_d;
    logic                    pulse_m_q, pulse_m_d;

    sat_res_t add_r;
    int       sum;

    assign add_r = sat_add(int'(acc_q), int'(rate_i), ACC_W);
    assign sum   = $signed(add_r.val);

    // Next-state: DAT handled on the old state first, then the ASW accumulate/decide step
    always_comb begin
        // NOTE: every variable gets a default here so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        sat_d     = sat_q & ~clr_flags_i;
        late_d    = late_q & ~clr_flags_i;

        case (state_q)
            ST_PEND_P, ST_PEND_M: begin
                if (dat_e_i) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase

        if (asw_e_i && enable_i) begin
            acc_d = ACC_W'(sum);
            if (add_r.clip) begin
                sat_d = 1'b1;
            end
            // A decision is only taken when the channel was idle before this cycle
            if (state_q == ST_IDLE) begin
                if (sum >= THRESH) begin
                    acc_d   = ACC_W'(sum - THRESH);
                    state_d = ST_PEND_P;
                    dir_d   = 1'b0;
                end else if (sum <= -THRESH) begin
                    acc_d   = ACC_W'(sum + THRESH);
                    state_d = ST_PEND_M;
                    dir_d   = 1'b1;
                end
            end else if (state_q == ST_PEND_P || state_q == ST_PEND_M) begin
                late_d = 1'b1;
            end
        end

        pulse_p_d = (state_d == ST_PULSE) && !dir_d;
        pulse_m_d = (state_d == ST_PULSE) && dir_d;
    end

    // State registers; async reset drops any pulse in flight and discards the backlog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            sat_q     <= 1'b0;
            late_q    <= 1'b0;
            pulse_p_q <= 1'b0;
            pulse_m_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from the pre-edge values.
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            sat_q     <= sat_d;
            late_q    <= late_d;
            pulse_p_q <= pulse_p_d;
            pulse_m_q <= pulse_m_d;
        end
    end

    assign pulse_p_o = pulse_p_q;
    assign pulse_m_o = pulse_m_q;
    assign sat_o     = sat_q;
    assign late_o    = late_q;

endmodule

// File: rtl/pipa_pulse_gen.sv
// PIPA pulse generator: synchronises the A24 PIPASW/PIPDAT strobes and drives three axis channels.
module pipa_pulse_gen
    import pipa_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int THRESH    = DEF_THRESH,
    parameter int PULSE_CYC = DEF_PULSE_CYC
) (
    input  logic                    CLOCK,
    input  logic                    rst,
    input  logic                    PIPASW,
    input  logic                    PIPDAT,
    input  logic                    enable,
    input  logic signed [ACC_W-1:0] rate_x,
    input  logic signed [ACC_W-1:0] rate_y,
    input  logic signed [ACC_W-1:0] rate_z,
    input  logic                    clr_flags,
    output logic                    PIPXP,
    output logic                    PIPXM,
    output logic                    PIPYP,
    output logic                    PIPYM,
    output logic                    PIPGZp,
    output logic                    PIPGZm,
    output logic [2:0]              sat,
    output logic [2:0]              late
);

    logic [2:0] asw_sync_q;
    logic [2:0] dat_sync_q;
    logic       asw_e;
    logic       dat_e;
    logic [2:0] pulse_p;
    logic [2:0] pulse_m;

    // Two-flop synchronisers with a third flop for rising-edge detection
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            asw_sync_q <= '0;
            dat_sync_q <= '0;
        end else begin
            asw_sync_q <= {asw_sync_q[1:0], PIPASW};
            dat_sync_q <= {dat_sync_q[1:0], PIPDAT};
        end
    end

    assign asw_e = asw_sync_q[1] & ~asw_sync_q[2];
    assign dat_e = dat_sync_q[1] & ~dat_sync_q[2];

    pipa_axis #(.ACC_W(ACC_W), .THRESH(THRESH), .PULSE_CYC(PULSE_CYC)) u_axis_x (
        .clk         (CLOCK),
        .rst_n       (rst),
        .asw_e_i     (asw_e),
        .dat_e_i     (dat_e),
        .enable_i    (enable),
        .rate_i      (rate_x),
        .clr_flags_i (clr_flags),
        .pulse_p_o   (pulse_p[AX_X]),
        .pulse_m_o   (pulse_m[AX_X]),
        .sat_o       (sat[AX_X]),
        .late_o      (late[AX_X])
    );

    pipa_axis #(.ACC_W(ACC_W), .THRESH(THRESH), .PULSE_CYC(PULSE_CYC)) u_axis_y (
        .clk         (CLOCK),
        .rst_n       (rst),
        .asw_e_i     (asw_e),
        .dat_e_i     (dat_e),
        .enable_i    (enable),
        .rate_i      (rate_y),
        .clr_flags_i (clr_flags),
        .pulse_p_o   (pulse_p[AX_Y]),
        .pulse_m_o   (pulse_m[AX_Y]),
        .sat_o       (sat[AX_Y]),
        .late_o      (late[AX_Y])
    );

    pipa_axis #(.ACC_W(ACC_W), .THRESH(THRESH), .PULSE_CYC(PULSE_CYC)) u_axis_z (
        .clk         (CLOCK),
        .rst_n       (rst),
        .asw_e_i     (asw_e),
        .dat_e_i     (dat_e),
        .enable_i    (enable),
        .rate_i      (rate_z),
        .clr_flags_i (clr_flags),
        .pulse_p_o   (pulse_p[AX_Z]),
        .pulse_m_o   (pulse_m[AX_Z]),
        .sat_o       (sat[AX_Z]),
        .late_o      (late[AX_Z])
    );

    assign PIPXP  = pulse_p[AX_X];
    assign PIPXM  = pulse_m[AX_X];
    assign PIPYP  = pulse_p[AX_Y];
    assign PIPYM  = pulse_m[AX_Y];
    assign PIPGZp = pulse_p[AX_Z];
    assign PIPGZm = pulse_m[AX_Z];

endmodule

// File: tb/tb_pipa_pulse_gen.sv
// Directed scoreboard bench for pipa_pulse_gen: stimulus pushes expected pulses, a monitor pops them.
module tb_pipa_pulse_gen;

    logic               CLOCK = 1'b0;
    logic               rst = 1'b0;
    logic               PIPASW = 1'b0;
    logic               PIPDAT = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] rate_x = '0;
    logic signed [15:0] rate_y = '0;
    logic signed [15:0] rate_z = '0;
    logic               clr_flags = 1'b0;
    logic               PIPXP, PIPXM, PIPYP, PIPYM, PIPGZp, PIPGZm;
    logic [2:0]         sat, late;

    pipa_pulse_gen u_dut (
        .CLOCK     (CLOCK),
        .rst       (rst),
        .PIPASW    (PIPASW),
        .PIPDAT    (PIPDAT),
        .enable    (enable),
        .rate_x    (rate_x),
        .rate_y    (rate_y),
        .rate_z    (rate_z),
        .clr_flags (clr_flags),
        .PIPXP     (PIPXP),
        .PIPXM     (PIPXM),
        .PIPYP     (PIPYP),
        .PIPYM     (PIPYM),
        .PIPGZp    (PIPGZp),
        .PIPGZm    (PIPGZm),
        .sat       (sat),
        .late      (late)
    );

    always #5 CLOCK = ~CLOCK;

    // Output index: 0 XP, 1 XM, 2 YP, 3 YM, 4 ZP, 5 ZM
    logic [5:0] outs;
    assign outs = {PIPGZm, PIPGZp, PIPYM, PIPYP, PIPXM, PIPXP};

    typedef struct {
        int idx;
        int width;
        int period;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   period_no = 0;
    int   pm_viol = 0;
    int   width_cnt[6];

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic expect_pulse(input int idx, input int width, input int per);
        exp_t e;
        e.idx    = idx;
        e.width  = width;
        e.period = per;
        exp_q.push_back(e);
    endtask

    // Monitor: measures each pulse at its falling edge and compares with the scoreboard head
    initial begin
        for (int i = 0; i < 6; i++) width_cnt[i] = 0;
    end

    always @(negedge CLOCK) begin
        if ((PIPXP && PIPXM) || (PIPYP && PIPYM) || (PIPGZp && PIPGZm)) pm_viol++;
        for (int i = 0; i < 6; i++) begin
            if (outs[i]) begin
                width_cnt[i]++;
            end else if (width_cnt[i] != 0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: output %0d width %0d in period %0d", i, width_cnt[i], period_no);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_output", i, e.idx);
                    check("pulse_width", width_cnt[i], e.width);
                    check("pulse_period", period_no, e.period);
                end
                width_cnt[i] = 0;
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b0;
        repeat (3) @(negedge CLOCK);
        rst = 1'b1;
        @(negedge CLOCK);
    endtask

    // One interrogation period: optional PIPASW strobe, then optional PIPDAT strobe
    task automatic period(input bit asw, input bit dat);
        period_no++;
        @(negedge CLOCK);
        if (asw) begin
            PIPASW = 1'b1;
            repeat (4) @(negedge CLOCK);
            PIPASW = 1'b0;
            repeat (4) @(negedge CLOCK);
        end
        if (dat) begin
            PIPDAT = 1'b1;
            repeat (4) @(negedge CLOCK);
            PIPDAT = 1'b0;
        end
        repeat (12) @(negedge CLOCK);
    endtask

    // Period where PIPASW and PIPDAT rise on the same clock
    task automatic period_both();
        period_no++;
        @(negedge CLOCK);
        PIPASW = 1'b1;
        PIPDAT = 1'b1;
        repeat (4) @(negedge CLOCK);
        PIPASW = 1'b0;
        PIPDAT = 1'b0;
        repeat (14) @(negedge CLOCK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        // Reset state
        repeat (3) @(negedge CLOCK);
        check("reset_outputs", outs, 0);
        check("reset_sat", sat, 0);
        check("reset_late", late, 0);
        rst = 1'b1;
        enable = 1'b1;
        @(negedge CLOCK);

        // 1: one X quantum per period, eight plus pulses
        rate_x = 16'sd1024;
        for (int i = 1; i <= 8; i++) begin
            expect_pulse(0, 4, period_no + 1);
            period(1'b1, 1'b1);
        end
        check("t1_acc_x", u_dut.u_axis_x.acc_q, 0);
        check("t1_late", late, 0);
        check("t1_sat", sat, 0);
        rate_x = '0;

        // 2: quarter-quantum Y rate, pulse every fourth period
        apply_reset();
        rate_y = 16'sd256;
        for (int i = 1; i <= 8; i++) begin
            if (i % 4 == 0) expect_pulse(2, 4, period_no + 1);
            period(1'b1, 1'b1);
        end
        check("t2_acc_y", u_dut.u_axis_y.acc_q, 0);
        check("t2_late", late, 0);
        rate_y = '0;

        // 3: Z minus backlog builds without DAT, then drains one per period
        apply_reset();
        rate_z = -16'sd3072;
        for (int i = 0; i < 4; i++) period(1'b1, 1'b0);
        check("t3_late", late, 3'b100);
        check("t3_acc_z", u_dut.u_axis_z.acc_q, -11264);
        rate_z = '0;
        for (int i = 0; i < 4; i++) begin
            expect_pulse(5, 4, period_no + 1);
            period(1'b1, 1'b1);
        end
        check("t3_acc_z_drained", u_dut.u_axis_z.acc_q, -8192);
        @(negedge CLOCK);
        clr_flags = 1'b1;
        @(negedge CLOCK);
        clr_flags = 1'b0;
        check("t3_late_cleared", late, 0);

        // 4: X saturation and flag clear
        apply_reset();
        rate_x = 16'sd32767;
        period(1'b1, 1'b0);
        check("t4_sat_before_clip", sat, 0);
        check("t4_acc_first", u_dut.u_axis_x.acc_q, 31743);
        period(1'b1, 1'b0);
        check("t4_sat", sat, 3'b001);
        check("t4_acc_clip", u_dut.u_axis_x.acc_q, 32767);
        @(negedge CLOCK);
        clr_flags = 1'b1;
        @(negedge CLOCK);
        clr_flags = 1'b0;
        check("t4_sat_cleared", sat, 0);
        check("t4_late_cleared", late, 0);
        rate_x = '0;
        expect_pulse(0, 4, period_no + 1);
        period(1'b0, 1'b1);

        // 5: ASW and DAT on the same clock while PEND_P
        apply_reset();
        rate_x = 16'sd1024;
        period(1'b1, 1'b0);
        expect_pulse(0, 4, period_no + 1);
        period_both();
        check("t5_acc_no_decision", u_dut.u_axis_x.acc_q, 1024);
        rate_x = '0;
        expect_pulse(0, 4, period_no + 1);
        period(1'b1, 1'b1);
        check("t5_acc_after", u_dut.u_axis_x.acc_q, 0);

        // 6: reset during a pulse, then a zero-rate period issues nothing
        apply_reset();
        rate_x = 16'sd1024;
        period_no++;
        expect_pulse(0, 2, period_no);
        @(negedge CLOCK);
        PIPASW = 1'b1;
        repeat (4) @(negedge CLOCK);
        PIPASW = 1'b0;
        repeat (4) @(negedge CLOCK);
        PIPDAT = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLOCK);
            if (PIPXP) seen = 1'b1;
        end
        check("t6_pulse_started", seen, 1);
        @(negedge CLOCK);
        #2 rst = 1'b0;
        #1 check("t6_async_drop", outs, 0);
        PIPDAT = 1'b0;
        rate_x = '0;
        repeat (3) @(negedge CLOCK);
        rst = 1'b1;
        @(negedge CLOCK);
        period(1'b1, 1'b1);
        check("t6_acc_after", u_dut.u_axis_x.acc_q, 0);

        repeat (20) @(negedge CLOCK);
        check("scoreboard_empty", exp_q.size(), 0);
        check("pm_exclusive", pm_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
